// File: rtl/mem_arbiter_if.sv
// Purpose: bundles the fetch port, data port and unified-memory port of the memory arbiter.
// Latency: none; this is wiring only.
// Backpressure: requests are held by the core until the matching gnt pulse; memory stalls via mem_gnt_i.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  // core side
  logic            flush_i;
  logic            if_req_i;
  logic [XLEN-1:0] if_adr_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [31:0]     if_rdata_o;
  logic            d_req_i;
  logic [XLEN-1:0] d_adr_i;
  logic            d_we_i;
  logic [XLEN-1:0] d_wdata_i;
  logic [2:0]      d_size_i;
  logic            d_gnt_o;
  logic            d_rvalid_o;
  logic [XLEN-1:0] d_rdata_o;
  // memory side
  logic            mem_req_o;
  logic [XLEN-1:0] mem_adr_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [2:0]      mem_size_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  // arbiter view
  modport slave (
    input  flush_i, if_req_i, if_adr_i, d_req_i, d_adr_i, d_we_i, d_wdata_i, d_size_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_req_o, mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o
  );

  // core + memory view
  modport master (
    output flush_i, if_req_i, if_adr_i, d_req_i, d_adr_i, d_we_i, d_wdata_i, d_size_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_req_o, mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-ported memory between instruction fetch and load/store, data first, fetch anti-starvation.
// Latency: request to mem_req_o 1 cycle; gnt same cycle as mem_gnt_i; rvalid combinational from mem_rvalid_i.
// Backpressure: one transaction outstanding; requesters hold req until gnt, memory stalls by holding mem_gnt_i low.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  state_e          state_q, state_d;
  logic            fetch_own_q, fetch_own_d;   // 1 = fetch owns the current transaction
  logic [XLEN-1:0] adr_q, adr_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      size_q, size_d;
  logic            discard_q, discard_d;       // fetch flushed: suppress its gnt/rvalid
  logic [CNT_W-1:0] cnt_q, cnt_d;              // consecutive data grants while fetch waits
  logic            fetch_ok;
  logic            pick_data;
  logic            f_grant;
  logic            d_grant;

  // Memory port is driven straight from the latched request so it cannot move during a stall.
  assign bus.mem_req_o   = (state_q == ISSUE);
  assign bus.mem_adr_o   = adr_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_size_o  = size_q;
  assign bus.if_rdata_o  = bus.mem_rdata_i[31:0];
  assign bus.d_rdata_o   = bus.mem_rdata_i;

  // Next-state, request selection, response routing and starvation counter.
  always_comb begin
    state_d         = state_q;
    fetch_own_d     = fetch_own_q;
    adr_d           = adr_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    size_d          = size_q;
    discard_d       = discard_q;
    cnt_d           = cnt_q;
    bus.if_gnt_o    = 1'b0;
    bus.d_gnt_o     = 1'b0;
    bus.if_rvalid_o = 1'b0;
    bus.d_rvalid_o  = 1'b0;
    // A flushed fetch request is not a candidate at all.
    fetch_ok  = bus.if_req_i && !bus.flush_i;
    pick_data = bus.d_req_i && !(fetch_ok && (cnt_q == LIMIT_C));
    f_grant   = (state_q == ISSUE) && fetch_own_q && bus.mem_gnt_i;
    d_grant   = (state_q == ISSUE) && !fetch_own_q && bus.mem_gnt_i;

    case (state_q)
      IDLE: begin
        if (pick_data) begin
          fetch_own_d = 1'b0;
          adr_d       = bus.d_adr_i;
          we_d        = bus.d_we_i;
          wdata_d     = bus.d_wdata_i;
          size_d      = bus.d_size_i;
          discard_d   = 1'b0;
          state_d     = ISSUE;
        end else if (fetch_ok) begin
          fetch_own_d = 1'b1;
          adr_d       = bus.if_adr_i;
          we_d        = 1'b0;
          wdata_d     = '0;
          size_d      = 3'b010;
          discard_d   = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // The memory request is never retracted; a flush only hides the fetch from the core.
        if (fetch_own_q && bus.flush_i) discard_d = 1'b1;
        if (bus.mem_gnt_i) begin
          if (fetch_own_q) begin
            bus.if_gnt_o = !(discard_q || bus.flush_i);
            state_d      = WAIT;
          end else begin
            bus.d_gnt_o = 1'b1;
            state_d     = we_q ? IDLE : WAIT;   // stores complete at grant
          end
        end
      end
      WAIT: begin
        if (fetch_own_q && bus.flush_i) discard_d = 1'b1;
        if (bus.mem_rvalid_i) begin
          if (fetch_own_q) bus.if_rvalid_o = !(discard_q || bus.flush_i);
          else             bus.d_rvalid_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!bus.if_req_i || f_grant) cnt_d = '0;
    else if (d_grant && (cnt_q < LIMIT_C)) cnt_d = cnt_q + 1'b1;
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q     <= IDLE;
      fetch_own_q <= 1'b0;
      adr_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      size_q      <= 3'b000;
      discard_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      fetch_own_q <= fetch_own_d;
      adr_q       <= adr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      discard_q   <= discard_d;
      cnt_q       <= cnt_d;
    end
  end

  a_gnt_in_issue: assert property (@(posedge clk) disable iff (reset_n)
    (bus.if_gnt_o || bus.d_gnt_o) |-> (state_q == ISSUE));
  a_rvalid_in_wait: assert property (@(posedge clk) disable iff (reset_n)
    (bus.if_rvalid_o || bus.d_rvalid_o) |-> (state_q == WAIT));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset_n)
    !(bus.if_gnt_o && bus.d_gnt_o));
  a_mem_stable: assert property (@(posedge clk) disable iff (reset_n)
    (bus.mem_req_o && !bus.mem_gnt_i) |=>
      $stable({bus.mem_adr_o, bus.mem_we_o, bus.mem_wdata_o, bus.mem_size_o}));

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed self-checking bench for mem_arbiter (per-cycle vector table plus multi-cycle sequences).
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled 4 units after it.
// Backpressure: memory grant/rvalid timing is driven explicitly by each vector or sequence.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(32)) bus ();

  mem_arbiter #(.XLEN(32), .STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic [31:0] da; logic dw; logic [31:0] dwd; logic [2:0] ds;
    logic        g;   logic rv; logic [31:0] rd;
    logic        er;  logic [31:0] ea; logic ew; logic [31:0] ewd; logic [2:0] es;
    logic        eig; logic eiv; logic edg; logic edv; logic [31:0] erd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ir, input logic [31:0] ia,
                     input logic dr, input logic [31:0] da, input logic dw,
                     input logic [31:0] dwd, input logic [2:0] ds,
                     input logic g, input logic rv, input logic [31:0] rd,
                     input logic er, input logic [31:0] ea, input logic ew,
                     input logic [31:0] ewd, input logic [2:0] es,
                     input logic eig, input logic eiv, input logic edg, input logic edv,
                     input logic [31:0] erd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.dw = dw; v.dwd = dwd; v.ds = ds;
    v.g = g; v.rv = rv; v.rd = rd;
    v.er = er; v.ea = ea; v.ew = ew; v.ewd = ewd; v.es = es;
    v.eig = eig; v.eiv = eiv; v.edg = edg; v.edv = edv; v.erd = erd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.flush_i = 1'b0;  bus.if_req_i = 1'b0; bus.if_adr_i = '0;
    bus.d_req_i = 1'b0;  bus.d_adr_i = '0;    bus.d_we_i = 1'b0;
    bus.d_wdata_i = '0;  bus.d_size_i = 3'b000;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pulses(input string tag, input logic ig, input logic iv,
                            input logic dg, input logic dv);
    chk({tag, "_if_gnt"},    32'(bus.if_gnt_o),    32'(ig));
    chk({tag, "_if_rvalid"}, 32'(bus.if_rvalid_o), 32'(iv));
    chk({tag, "_d_gnt"},     32'(bus.d_gnt_o),     32'(dg));
    chk({tag, "_d_rvalid"},  32'(bus.d_rvalid_o),  32'(dv));
  endtask

  // Watchdog: every loop is bounded, this only catches a stuck simulator.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndg, nfg, ngnt;
    bit got;
    idle_inputs();
    reset_n = 1'b1;

    //     ir ia        dr da        dw dwd          ds    g  rv rd           | er ea        ew ewd          es    ig iv dg dv rdata
    // single fetch, grant 2 cycles after mem_req
    add(0, 32'h0,     0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 0, 0, 32'h0);
    add(1, 32'h100,   0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 0, 0, 32'h0);
    add(1, 32'h100,   0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 32'h0,        1, 32'h100, 0, 32'h0,        3'd2, 0, 0, 0, 0, 32'h0);
    add(1, 32'h100,   0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 32'h0,        1, 32'h100, 0, 32'h0,        3'd2, 0, 0, 0, 0, 32'h0);
    add(1, 32'h100,   0, 32'h0,   0, 32'h0,        3'd0, 1, 0, 32'h0,        1, 32'h100, 0, 32'h0,        3'd2, 1, 0, 0, 0, 32'h0);
    add(0, 32'h0,     0, 32'h0,   0, 32'h0,        3'd0, 0, 1, 32'h00500093, 0, 32'h0,   0, 32'h0,        3'd0, 0, 1, 0, 0, 32'h00500093);
    add(0, 32'h0,     0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 0, 0, 32'h0);
    // store then load
    add(0, 32'h0,     1, 32'h200, 1, 32'hDEADBEEF, 3'd2, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 0, 0, 32'h0);
    add(0, 32'h0,     1, 32'h200, 1, 32'hDEADBEEF, 3'd2, 1, 0, 32'h0,        1, 32'h200, 1, 32'hDEADBEEF, 3'd2, 0, 0, 1, 0, 32'h0);
    add(0, 32'h0,     1, 32'h200, 0, 32'h0,        3'd2, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 0, 0, 32'h0);
    add(0, 32'h0,     1, 32'h200, 0, 32'h0,        3'd2, 1, 0, 32'h0,        1, 32'h200, 0, 32'h0,        3'd2, 0, 0, 1, 0, 32'h0);
    add(0, 32'h0,     0, 32'h0,   0, 32'h0,        3'd0, 0, 1, 32'hDEADBEEF, 0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 0, 1, 32'hDEADBEEF);
    add(0, 32'h0,     0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 0, 0, 32'h0);
    // simultaneous requests: data wins; rvalid alongside gnt in ISSUE is ignored; then fetch
    add(1, 32'h104,   1, 32'h400, 0, 32'h0,        3'd1, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 0, 0, 32'h0);
    add(1, 32'h104,   1, 32'h400, 0, 32'h0,        3'd1, 1, 1, 32'hBAD,      1, 32'h400, 0, 32'h0,        3'd1, 0, 0, 1, 0, 32'h0);
    add(1, 32'h104,   0, 32'h0,   0, 32'h0,        3'd0, 0, 1, 32'h12345678, 0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 0, 1, 32'h12345678);
    add(1, 32'h104,   0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 0, 0, 32'h0);
    add(1, 32'h104,   0, 32'h0,   0, 32'h0,        3'd0, 1, 0, 32'h0,        1, 32'h104, 0, 32'h0,        3'd2, 1, 0, 0, 0, 32'h0);
    add(0, 32'h0,     0, 32'h0,   0, 32'h0,        3'd0, 0, 1, 32'hCAFEF00D, 0, 32'h0,   0, 32'h0,        3'd0, 0, 1, 0, 0, 32'hCAFEF00D);
    add(0, 32'h0,     0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0,        3'd0, 0, 0, 0, 0, 32'h0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #3;
    chk("rst_mem_req",   32'(bus.mem_req_o),  32'h0);
    chk("rst_mem_adr",   bus.mem_adr_o,       32'h0);
    chk("rst_mem_we",    32'(bus.mem_we_o),   32'h0);
    chk("rst_mem_wdata", bus.mem_wdata_o,     32'h0);
    chk("rst_mem_size",  32'(bus.mem_size_o), 32'h0);
    chk("rst_state",     32'(dut.state_q),    32'h0);
    chk("rst_cnt",       32'(dut.cnt_q),      32'h0);
    chk_pulses("rst", 0, 0, 0, 0);
    next_cycle();

    // vector table, one row per clock
    for (int i = 0; i < tbl.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      bus.if_req_i = tbl[i].ir;  bus.if_adr_i = tbl[i].ia;
      bus.d_req_i  = tbl[i].dr;  bus.d_adr_i  = tbl[i].da;  bus.d_we_i = tbl[i].dw;
      bus.d_wdata_i = tbl[i].dwd; bus.d_size_i = tbl[i].ds;
      bus.mem_gnt_i = tbl[i].g;  bus.mem_rvalid_i = tbl[i].rv; bus.mem_rdata_i = tbl[i].rd;
      #3;
      chk({t, "_mem_req"}, 32'(bus.mem_req_o), 32'(tbl[i].er));
      if (tbl[i].er) begin
        chk({t, "_mem_adr"},  bus.mem_adr_o,       tbl[i].ea);
        chk({t, "_mem_we"},   32'(bus.mem_we_o),   32'(tbl[i].ew));
        chk({t, "_mem_size"}, 32'(bus.mem_size_o), 32'(tbl[i].es));
        if (tbl[i].ew) chk({t, "_mem_wdata"}, bus.mem_wdata_o, tbl[i].ewd);
      end
      chk_pulses(t, tbl[i].eig, tbl[i].eiv, tbl[i].edg, tbl[i].edv);
      if (tbl[i].eiv) chk({t, "_if_rdata"}, bus.if_rdata_o, tbl[i].erd);
      if (tbl[i].edv) chk({t, "_d_rdata"},  bus.d_rdata_o,  tbl[i].erd);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // starvation: fetch held, stores back to back, memory grants immediately
    bus.if_req_i = 1'b1; bus.if_adr_i = 32'h800;
    bus.d_req_i = 1'b1;  bus.d_adr_i = 32'h900; bus.d_we_i = 1'b1;
    bus.d_wdata_i = 32'h1; bus.d_size_i = 3'b010;
    ndg = 0; nfg = 0; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      bus.mem_gnt_i = bus.mem_req_o;
      #3;
      if (bus.d_gnt_o) ndg++;
      if (bus.if_gnt_o) begin nfg++; got = 1'b1; end
      next_cycle();
    end
    chk("starve_data_grants",  32'(ndg), 32'd4);
    chk("starve_fetch_grants", 32'(nfg), 32'd1);
    chk("starve_cnt_cleared",  32'(dut.cnt_q), 32'd0);
    idle_inputs();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h13;
    #3;
    chk("starve_if_rvalid", 32'(bus.if_rvalid_o), 32'd1);
    next_cycle();
    idle_inputs();
    next_cycle();

    // flush while the fetch waits for data; pending load goes next
    bus.if_req_i = 1'b1; bus.if_adr_i = 32'h300;
    next_cycle();
    bus.mem_gnt_i = 1'b1;
    bus.d_req_i = 1'b1; bus.d_adr_i = 32'h500; bus.d_we_i = 1'b0; bus.d_size_i = 3'b010;
    #3;
    chk("flush_if_gnt", 32'(bus.if_gnt_o), 32'd1);
    next_cycle();
    bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.flush_i = 1'b1;
    #3;
    chk("flush_mem_req_wait", 32'(bus.mem_req_o), 32'd0);
    next_cycle();
    bus.flush_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h77;
    #3;
    chk_pulses("flush_resp", 0, 0, 0, 0);
    next_cycle();
    bus.mem_rvalid_i = 1'b0;
    #3;
    chk("flush_idle_mem_req", 32'(bus.mem_req_o), 32'd0);
    next_cycle();
    bus.mem_gnt_i = 1'b1;
    #3;
    chk("flush_next_mem_req", 32'(bus.mem_req_o), 32'd1);
    chk("flush_next_mem_adr", bus.mem_adr_o, 32'h500);
    chk("flush_next_d_gnt",   32'(bus.d_gnt_o), 32'd1);
    next_cycle();
    bus.d_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h55;
    #3;
    chk("flush_d_rvalid", 32'(bus.d_rvalid_o), 32'd1);
    chk("flush_d_rdata",  bus.d_rdata_o, 32'h55);
    next_cycle();
    idle_inputs();
    next_cycle();

    // reset in the middle of ISSUE, then a stray rvalid
    bus.d_req_i = 1'b1; bus.d_adr_i = 32'h600; bus.d_we_i = 1'b0; bus.d_size_i = 3'b010;
    next_cycle();
    #3;
    chk("rmid_mem_req_before", 32'(bus.mem_req_o), 32'd1);
    reset_n = 1'b1;
    next_cycle();
    reset_n = 1'b0;
    idle_inputs();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h99;
    #3;
    chk("rmid_mem_req_after", 32'(bus.mem_req_o), 32'd0);
    chk("rmid_state",         32'(dut.state_q),   32'd0);
    chk_pulses("rmid", 0, 0, 0, 0);
    next_cycle();
    #3;
    chk_pulses("rmid_stray", 0, 0, 0, 0);
    next_cycle();
    idle_inputs();
    next_cycle();

    // memory stall during a load: bus stable, exactly one grant
    bus.d_req_i = 1'b1; bus.d_adr_i = 32'h700; bus.d_we_i = 1'b0; bus.d_size_i = 3'b001;
    next_cycle();
    ngnt = 0;
    for (int c = 0; c < 5; c++) begin
      #3;
      chk($sformatf("stall%0d_adr", c),  bus.mem_adr_o,       32'h700);
      chk($sformatf("stall%0d_we", c),   32'(bus.mem_we_o),   32'd0);
      chk($sformatf("stall%0d_size", c), 32'(bus.mem_size_o), 32'd1);
      if (bus.d_gnt_o) ngnt++;
      next_cycle();
    end
    bus.mem_gnt_i = 1'b1;
    #3;
    chk("stall_gnt_adr", bus.mem_adr_o, 32'h700);
    if (bus.d_gnt_o) ngnt++;
    next_cycle();
    bus.d_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hA5A5;
    #3;
    if (bus.d_gnt_o) ngnt++;
    chk("stall_gnt_count", 32'(ngnt), 32'd1);
    chk("stall_d_rvalid",  32'(bus.d_rvalid_o), 32'd1);
    chk("stall_d_rdata",   bus.d_rdata_o, 32'hA5A5);
    next_cycle();
    idle_inputs();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported memory between the core's instruction-fetch port and its load/store data port.
- Sits between the core's fetch/data request ports and the unified memory.
- Data accesses have priority; a starvation counter guarantees fetch progress.
- One transaction outstanding at a time; responses are routed back to the owning requester.

Parameters:
- XLEN, 32, address and data width.
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is waiting; after this many, fetch is forced.
- CNT_W, 3, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous reset, active-high: 1 = reset asserted.
- flush_i  in  1  pipeline flush from exe; discards fetch traffic.
- if_req_i  in  1  fetch request; held until if_gnt_o.
- if_adr_i  in  XLEN  fetch address.
- if_gnt_o  out  1  fetch request accepted by memory (1-cycle pulse).
- if_rvalid_o  out  1  fetch data valid (1-cycle pulse).
- if_rdata_o  out  32  fetched instruction.
- d_req_i  in  1  data request; held until d_gnt_o.
- d_adr_i  in  XLEN  data address.
- d_we_i  in  1  1 = store, 0 = load.
- d_wdata_i  in  XLEN  store data.
- d_size_i  in  3  access size, passed through unchanged.
- d_gnt_o  out  1  data request accepted (1-cycle pulse).
- d_rvalid_o  out  1  load data valid (1-cycle pulse, loads only).
- d_rdata_o  out  XLEN  load data.
- mem_req_o  out  1  memory request.
- mem_adr_o  out  XLEN  memory address.
- mem_we_o  out  1  memory write enable.
- mem_wdata_o  out  XLEN  memory write data.
- mem_size_o  out  3  memory access size; 3'b010 (word) for fetch.
- mem_gnt_i  in  1  memory accepted the request this cycle.
- mem_rvalid_i  in  1  read data valid; never asserted for stores.
- mem_rdata_i  in  XLEN  read data.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT.
- Reset (reset_n=1 at a clock edge):
  - FSM to IDLE, owner cleared, starvation counter to 0.
  - mem_req_o, if_gnt_o, d_gnt_o, if_rvalid_o and d_rvalid_o all 0.
  - mem_adr_o, mem_wdata_o, mem_we_o, mem_size_o all 0.
  - Reset mid-transaction abandons it; any later mem_rvalid_i is ignored until a new transaction is issued.
- IDLE:
  - Selection rule: if d_req_i=1 and not (if_req_i=1 and counter==STARVE_LIMIT), select data; else if if_req_i=1, select fetch.
  - If flush_i=1, if_req_i is ignored for selection.
  - On selection, latch owner, address, we, wdata and size into registers, and go to ISSUE.
  - Request-to-mem_req_o latency is 1 cycle.
- ISSUE:
  - mem_req_o=1; mem_* outputs driven from the registers, stable until mem_gnt_i.
  - On mem_gnt_i=1: pulse the owner's gnt_o in the same cycle.
  - Next state: stores go to IDLE (complete at grant); loads and fetches go to WAIT.
  - If flush_i=1 while a fetch is in ISSUE, the request is still completed to memory (no retraction), but the grant pulse is suppressed and the response is marked discard.
- WAIT:
  - On mem_rvalid_i=1, route it combinationally to the owner's rvalid_o; rdata_o = mem_rdata_i, with if_rdata_o = mem_rdata_i[31:0].
  - Then go to IDLE. There is no back-to-back issue; IDLE always costs 1 cycle.
  - flush_i=1 while a fetch is in WAIT marks it discard. A discarded response: if_rvalid_o stays 0; the FSM still waits for mem_rvalid_i, then returns to IDLE.
  - flush_i has no effect on data transactions.
- Starvation counter:
  - On each data grant while if_req_i=1: increment, saturating at STARVE_LIMIT.
  - Cleared on a fetch grant, or in any cycle with if_req_i=0.
- Simultaneous events:
  - d_req_i and if_req_i together in IDLE with counter<STARVE_LIMIT: data wins.
  - Same, with counter==STARVE_LIMIT: fetch wins.
  - mem_gnt_i and mem_rvalid_i in the same cycle in ISSUE: rvalid is ignored, since memory latency is ≥1 cycle by contract.
- Outputs not owned by the current transaction stay 0. if_rdata_o and d_rdata_o are don't-care when their rvalid is 0.
- Assertions:
  - No gnt or rvalid pulse outside ISSUE/WAIT.
  - if_gnt_o and d_gnt_o never high together.
  - mem_* outputs stable while mem_req_o=1 and mem_gnt_i=0.

Test Plan:
1. Single fetch: if_req_i=1, if_adr_i=0x100; memory grants 2 cycles after mem_req_o and returns 0x00500093 one cycle after grant -> mem_req_o rises 1 cycle after the request, mem_adr_o=0x100, mem_size_o=3'b010, one if_gnt_o pulse, if_rvalid_o=1 with if_rdata_o=0x00500093, FSM back to IDLE.
2. Store then load: store to 0x200 with data 0xDEADBEEF and size 3'b010 -> mem_we_o=1 and d_gnt_o pulse with no d_rvalid_o. Then load 0x200 with memory returning 0xDEADBEEF -> d_rvalid_o=1, d_rdata_o=0xDEADBEEF.
3. Starvation: if_req_i held at 1, d_req_i re-asserted continuously, STARVE_LIMIT=4 -> exactly 4 data grants, then 1 fetch grant, then the counter reads 0.
4. Flush in WAIT: fetch 0x300 granted, flush_i=1 one cycle before mem_rvalid_i -> if_rvalid_o stays 0; a pending d_req_i is issued in the cycle after IDLE is re-entered.
5. Reset mid-operation: reset_n=1 while in ISSUE with mem_gnt_i=0 -> next cycle mem_req_o=0, all gnt/rvalid outputs 0, FSM in IDLE. A stray mem_rvalid_i afterwards produces no rvalid pulse.
6. Memory stall: mem_gnt_i held at 0 for 5 cycles during a load -> mem_adr_o, mem_we_o and mem_size_o constant throughout, d_gnt_o pulses exactly once when mem_gnt_i=1.
